// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bundle for the receive-side deserializer.
// The slave modport is the deserializer; the master feeds bits and takes words.
interface deserializer_if #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
);
    logic                      ser_data_i;
    logic                      ser_data_val_i;
    logic [DATA_BUS_WIDTH-1:0] deser_data_o;
    logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o;
    logic                      deser_data_val_o;
    logic                      busy_o;
    logic                      drop_o;

    modport slave (
        input  ser_data_i,
        input  ser_data_val_i,
        output deser_data_o,
        output deser_data_mod_o,
        output deser_data_val_o,
        output busy_o,
        output drop_o
    );

    modport master (
        output ser_data_i,
        output ser_data_val_i,
        input  deser_data_o,
        input  deser_data_mod_o,
        input  deser_data_val_o,
        input  busy_o,
        input  drop_o
    );
endinterface

// File: rtl/deserializer.sv
// Reassembles MSB-first serial bursts into left-aligned parallel words.
// Full words end on their last bit; shorter bursts end on the first idle cycle.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic clk_i,
    input  logic arstn_i,
    deserializer_if.slave bus
);
    localparam int W = DATA_BUS_WIDTH;
    localparam int M = DATA_MOD_WIDTH;
    localparam logic [M-1:0] LAST_IDX = M'(W - 1);
    localparam logic [M:0]   LAST_CNT = (M + 1)'(W - 1);
    localparam logic [M:0]   MIN_CNT  = (M + 1)'(3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1
    } state_t;

    state_t         state_q, state_d;
    logic [M:0]     bit_cnt_q, bit_cnt_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   data_q, data_d;
    logic [M-1:0]   mod_q, mod_d;
    logic           val_q, val_d;
    logic           drop_q, drop_d;
    logic           rst_sync_q;
    logic [M-1:0]   wr_idx;

    // Assertion is immediate; release takes effect one edge later.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    assign wr_idx = LAST_IDX - bit_cnt_q[M-1:0];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        mod_d     = mod_q;
        val_d     = 1'b0;
        drop_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ser_data_val_i) begin
                    shreg_d        = '0;
                    shreg_d[W-1]   = bus.ser_data_i;
                    bit_cnt_d      = (M + 1)'(1);
                    state_d        = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.ser_data_val_i) begin
                    shreg_d[wr_idx] = bus.ser_data_i;
                    if (bit_cnt_q == LAST_CNT) begin
                        data_d    = shreg_d;
                        mod_d     = '0;
                        val_d     = 1'b1;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    if (bit_cnt_q >= MIN_CNT) begin
                        data_d = shreg_q;
                        mod_d  = bit_cnt_q[M-1:0];
                        val_d  = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            mod_q     <= '0;
            val_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            mod_q     <= mod_d;
            val_q     <= val_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.deser_data_o     = data_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.drop_o           = drop_q;
    assign bus.busy_o           = (state_q == COLLECT);
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: full, partial, dropped,
// back-to-back and mid-burst-reset scenarios with hand-derived expectations.
module tb_deserializer;
    logic clk_i;
    logic arstn_i;
    int   total;
    int   bad;

    deserializer_if #(.DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4)) bus ();

    deserializer #(.DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4)) dut (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.ser_data_i     = b;
        bus.ser_data_val_i = 1'b1;
        tick();
    endtask

    task automatic idle_cycle();
        bus.ser_data_i     = 1'b0;
        bus.ser_data_val_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        total++;
        if ({bus.deser_data_o, bus.deser_data_mod_o, bus.deser_data_val_o,
             bus.busy_o, bus.drop_o} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h mod=%0d val=%b busy=%b drop=%b want all 0",
                     bus.deser_data_o, bus.deser_data_mod_o, bus.deser_data_val_o,
                     bus.busy_o, bus.drop_o);
        end
    endtask

    task automatic test_full_word();
        logic [15:0] w;
        w = 16'hA5C3;
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i]);
            total++;
            if (bus.busy_o !== (i != 0)) begin
                bad++;
                $display("FAIL full_busy bit%0d: got %b want %b", 16 - i, bus.busy_o, i != 0);
            end
            total++;
            if (bus.deser_data_val_o !== (i == 0)) begin
                bad++;
                $display("FAIL full_val bit%0d: got %b want %b",
                         16 - i, bus.deser_data_val_o, i == 0);
            end
        end
        total++;
        if (bus.deser_data_o !== 16'hA5C3 || bus.deser_data_mod_o !== 4'd0) begin
            bad++;
            $display("FAIL full_data: got %h/%0d want a5c3/0",
                     bus.deser_data_o, bus.deser_data_mod_o);
        end
        idle_cycle();
        total++;
        if (bus.deser_data_val_o !== 1'b0 || bus.drop_o !== 1'b0) begin
            bad++;
            $display("FAIL full_pulse_width: got val=%b drop=%b want 0 0",
                     bus.deser_data_val_o, bus.drop_o);
        end
    endtask

    task automatic test_partial();
        logic [4:0] bits;
        bits = 5'b10110;
        for (int i = 4; i >= 0; i--) send_bit(bits[i]);
        total++;
        if (bus.deser_data_val_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL partial_early: got val=%b busy=%b want 0 1",
                     bus.deser_data_val_o, bus.busy_o);
        end
        idle_cycle();
        total++;
        if (bus.deser_data_val_o !== 1'b1 || bus.drop_o !== 1'b0) begin
            bad++;
            $display("FAIL partial_pulse: got val=%b drop=%b want 1 0",
                     bus.deser_data_val_o, bus.drop_o);
        end
        total++;
        if (bus.deser_data_o !== 16'hB000 || bus.deser_data_mod_o !== 4'd5) begin
            bad++;
            $display("FAIL partial_data: got %h/%0d want b000/5",
                     bus.deser_data_o, bus.deser_data_mod_o);
        end
        total++;
        if (bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL partial_busy: got %b want 0", bus.busy_o);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int          pulses;
        w      = {16'h1234, 16'hFFFF};
        pulses = 0;
        for (int i = 31; i >= 0; i--) begin
            send_bit(w[i]);
            total++;
            if (bus.deser_data_val_o !== (i == 16 || i == 0)) begin
                bad++;
                $display("FAIL b2b_val bit%0d: got %b want %b",
                         32 - i, bus.deser_data_val_o, i == 16 || i == 0);
            end
            if (bus.deser_data_val_o === 1'b1) begin
                pulses++;
                total++;
                if (bus.deser_data_o !== w[i+:16] || bus.deser_data_mod_o !== 4'd0) begin
                    bad++;
                    $display("FAIL b2b_data bit%0d: got %h/%0d want %h/0",
                             32 - i, bus.deser_data_o, bus.deser_data_mod_o, w[i+:16]);
                end
            end
        end
        idle_cycle();
        total++;
        if (pulses != 2 || bus.deser_data_val_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d val=%b want 2 0", pulses, bus.deser_data_val_o);
        end
    endtask

    task automatic test_drop();
        send_bit(1'b1);
        send_bit(1'b1);
        idle_cycle();
        total++;
        if (bus.drop_o !== 1'b1 || bus.deser_data_val_o !== 1'b0) begin
            bad++;
            $display("FAIL drop_pulse: got drop=%b val=%b want 1 0",
                     bus.drop_o, bus.deser_data_val_o);
        end
        total++;
        if (bus.deser_data_o !== 16'hFFFF || bus.deser_data_mod_o !== 4'd0) begin
            bad++;
            $display("FAIL drop_hold: got %h/%0d want ffff/0",
                     bus.deser_data_o, bus.deser_data_mod_o);
        end
        idle_cycle();
        total++;
        if (bus.drop_o !== 1'b0) begin
            bad++;
            $display("FAIL drop_width: got %b want 0", bus.drop_o);
        end
    endtask

    task automatic test_async_reset();
        int events;
        events = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        arstn_i = 1'b0;
        #1;
        total++;
        if ({bus.deser_data_o, bus.deser_data_mod_o, bus.deser_data_val_o,
             bus.busy_o, bus.drop_o} !== 23'd0) begin
            bad++;
            $display("FAIL async_clear: got data=%h mod=%0d val=%b busy=%b drop=%b want all 0",
                     bus.deser_data_o, bus.deser_data_mod_o, bus.deser_data_val_o,
                     bus.busy_o, bus.drop_o);
        end
        bus.ser_data_val_i = 1'b0;
        #4;
        arstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.deser_data_val_o !== 1'b0 || bus.drop_o !== 1'b0) events++;
        end
        total++;
        if (events != 0) begin
            bad++;
            $display("FAIL async_no_event: got %0d events want 0", events);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_cycle();
        total++;
        if (bus.deser_data_val_o !== 1'b1 || bus.deser_data_o !== 16'hA000 ||
            bus.deser_data_mod_o !== 4'd3) begin
            bad++;
            $display("FAIL async_after: got val=%b %h/%0d want 1 a000/3",
                     bus.deser_data_val_o, bus.deser_data_o, bus.deser_data_mod_o);
        end
        idle_cycle();
    endtask

    task automatic test_ser_stream();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'hBEEF;
        b = 16'h8001;
        for (int i = 15; i >= 6; i--) send_bit(a[i]);
        idle_cycle();
        total++;
        if (bus.deser_data_val_o !== 1'b1 || bus.deser_data_o !== 16'hBEC0 ||
            bus.deser_data_mod_o !== 4'd10) begin
            bad++;
            $display("FAIL stream_first: got val=%b %h/%0d want 1 bec0/10",
                     bus.deser_data_val_o, bus.deser_data_o, bus.deser_data_mod_o);
        end
        for (int i = 15; i >= 0; i--) send_bit(b[i]);
        total++;
        if (bus.deser_data_val_o !== 1'b1 || bus.deser_data_o !== 16'h8001 ||
            bus.deser_data_mod_o !== 4'd0) begin
            bad++;
            $display("FAIL stream_second: got val=%b %h/%0d want 1 8001/0",
                     bus.deser_data_val_o, bus.deser_data_o, bus.deser_data_mod_o);
        end
        idle_cycle();
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        arstn_i            = 1'b0;
        bus.ser_data_i     = 1'b0;
        bus.ser_data_val_i = 1'b0;
        #12;
        test_reset();
        arstn_i = 1'b1;
        tick();
        tick();
        test_full_word();
        test_partial();
        test_back_to_back();
        test_drop();
        test_async_reset();
        test_ser_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/deserializer.md
# deserializer

Receives the MSB-first serial bit stream produced by the serializer (`ser_data_o`/`ser_data_val_o`) and reassembles it into a parallel word. Each word comes with a bit count that uses the same `data_mod` encoding as the serializer input. The block sits directly downstream of the serializer on the receive side. It turns each contiguous burst of valid bits into one single-cycle, left-aligned parallel word.

## Interface

- `DATA_BUS_WIDTH`, default 16: parallel word width in bits. Must be ≥ 4.
- `DATA_MOD_WIDTH`, default 4: width of the bit-count field. Equals `$clog2(DATA_BUS_WIDTH)`.

- `clk_i`, input, 1: single clock; all logic is on the rising edge.
- `arstn_i`, input, 1: reset, asynchronous, active-low.
- `ser_data_i`, input, 1: serial data bit, MSB of the word first.
- `ser_data_val_i`, input, 1: `ser_data_i` is valid this cycle.
- `deser_data_o`, output, `DATA_BUS_WIDTH`: reassembled word, left-aligned. Bits not received are 0.
- `deser_data_mod_o`, output, `DATA_MOD_WIDTH`: number of valid bits. 0 means `DATA_BUS_WIDTH` bits.
- `deser_data_val_o`, output, 1: one-cycle pulse; `deser_data_o`/`deser_data_mod_o` are valid.
- `busy_o`, output, 1: a word is partially collected.
- `drop_o`, output, 1: one-cycle pulse; a burst of 1 or 2 bits was discarded.

## Operation

- **Reset.** Asserting `arstn_i` low immediately clears state, counter, shift register and every output to 0. Release is synchronized internally to the next `clk_i` edge.
- **State machine.**
  - IDLE: bit counter is 0.
  - COLLECT: bit counter is between 1 and `DATA_BUS_WIDTH`-1.
  - `busy_o` is 1 exactly while in COLLECT.
- **Bit capture.**
  - `bit_cnt` is `DATA_MOD_WIDTH`+1 bits wide.
  - Each cycle with `ser_data_val_i`=1 writes `ser_data_i` into `shreg[DATA_BUS_WIDTH-1-bit_cnt]` and increments `bit_cnt`.
  - IDLE→COLLECT occurs on the first valid bit.
- **Word end (a), full word.**
  - Triggered at the edge that samples the `DATA_BUS_WIDTH`-th valid bit.
  - On that edge the output registers load the full word including that bit, `deser_data_mod_o` is 0 and `deser_data_val_o` is 1.
  - Counter and shift register clear; state goes to IDLE.
  - A valid bit in the very next cycle starts a new word (back-to-back words allowed).
- **Word end (b), partial word.**
  - Triggered at the first edge sampling `ser_data_val_i`=0 while in COLLECT.
  - If `bit_cnt` ≥ 3: the output registers load `shreg`, `deser_data_mod_o` = `bit_cnt[DATA_MOD_WIDTH-1:0]` and `deser_data_val_o` = 1.
  - If `bit_cnt` is 1 or 2: nothing is loaded and `drop_o` pulses. This mirrors the serializer, which never sends 1- or 2-bit transfers.
  - In both cases: clear, go to IDLE.
- **Output hold.** `deser_data_o`/`deser_data_mod_o` hold their last value until the next load. `deser_data_val_o` and `drop_o` are high for exactly one cycle per event.
- **No back-pressure.** The downstream consumer must take each word on its valid cycle.
- **Unused state encodings** return to IDLE.

## Timing

- Full word: `deser_data_val_o` is high in the cycle right after the last bit's cycle (1-cycle latency).
- Partial word: `deser_data_val_o` or `drop_o` is high 2 cycles after the last bit's cycle, i.e. one cycle after the first invalid cycle.
- Minimum gap between words: 0 cycles for full words; 1 invalid cycle terminates a partial word.
- A full-word output pulse and capture of the next word's first bit can occur in the same cycle; both must take effect.
- Reset asserted mid-burst discards the partial word; no `deser_data_val_o` or `drop_o` is produced for it.
- Throughput: one bit per clock, sustained.

## Test plan

Parameters for all scenarios: `DATA_BUS_WIDTH`=16, `DATA_MOD_WIDTH`=4.

1. 16 contiguous valid bits of 0xA5C3, MSB first, then valid low → `deser_data_val_o` high 1 cycle after the 16th bit; data 0xA5C3, mod 0; `busy_o` high during bits 1–15.
2. 5 valid bits 1,0,1,1,0 then valid low → pulse 2 cycles after the last bit; data 0xB000, mod 5; `drop_o` stays 0.
3. 32 contiguous valid bits (0x1234 then 0xFFFF) → two pulses 16 cycles apart: 0x1234/mod 0, then 0xFFFF/mod 0; no lost or duplicated bit.
4. 2 valid bits then valid low → `drop_o` pulses once 2 cycles after the last bit; `deser_data_val_o` stays 0; outputs keep their previous word.
5. `arstn_i` low for half a cycle after 7 valid bits → all outputs 0 asynchronously, no pulse; then a 3-bit burst 1,0,1 → data 0xA000, mod 3.
6. Back-to-back with the serializer (`data_i`=0xBEEF, `data_mod_i`=10, then 0x8001 with mod 0) → 0xBEC0/mod 10, then 0x8001/mod 0.
